// File: rtl/midi_msg_parser.sv
// MIDI channel-voice byte parser: tracks running status, filters by channel and
// holds note/velocity/gate, last controller and pitch bend as registered buses.
module midi_msg_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [6:0]  o_note,
  output logic [6:0]  o_velocity,
  output logic        o_gate,
  output logic [6:0]  o_cc_num,
  output logic [6:0]  o_cc_val,
  output logic [13:0] o_bend,
  output logic        o_msg_valid
);

  typedef enum logic [1:0] {IDLE, D1, D2, SYSEX} state_t;

  state_t     state, state_n;
  logic [3:0] status, status_n;
  logic [3:0] chan, chan_n;
  logic [6:0] d1, d1_n;
  logic       rs_valid, rs_valid_n;
  logic       complete;
  logic [6:0] msg_d1, msg_d2;
  logic       one_byte_msg;
  logic       chan_ok;

  assign one_byte_msg = (status == 4'hC) || (status == 4'hD);
  assign chan_ok      = OMNI || (chan == CHANNEL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      status   <= 4'h0;
      chan     <= 4'h0;
      d1       <= 7'h00;
      rs_valid <= 1'b0;
    end else begin
      state    <= state_n;
      status   <= status_n;
      chan     <= chan_n;
      d1       <= d1_n;
      rs_valid <= rs_valid_n;
    end
  end

  // Status bytes re-sync the parser from any state; data bytes advance it.
  always_comb begin
    state_n    = state;
    status_n   = status;
    chan_n     = chan;
    d1_n       = d1;
    rs_valid_n = rs_valid;
    complete   = 1'b0;
    msg_d1     = d1;
    msg_d2     = i_byte[6:0];
    if (i_byte_valid) begin
      if (i_byte >= 8'hF8) begin
        state_n = state;
      end else if (i_byte[7] && (i_byte[7:4] != 4'hF)) begin
        status_n   = i_byte[7:4];
        chan_n     = i_byte[3:0];
        rs_valid_n = 1'b1;
        state_n    = D1;
      end else if (i_byte == 8'hF0) begin
        rs_valid_n = 1'b0;
        state_n    = SYSEX;
      end else if (i_byte[7]) begin
        rs_valid_n = 1'b0;
        state_n    = IDLE;
      end else begin
        case (state)
          IDLE, D1: begin
            if ((state == D1) || rs_valid) begin
              if (one_byte_msg) begin
                complete = 1'b1;
                msg_d1   = i_byte[6:0];
                state_n  = IDLE;
              end else begin
                d1_n    = i_byte[6:0];
                state_n = D2;
              end
            end
          end
          D2: begin
            complete = 1'b1;
            state_n  = IDLE;
          end
          default: state_n = state;
        endcase
      end
    end
  end

  // Output buses only move when a completed message passes the channel filter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_note      <= 7'h00;
      o_velocity  <= 7'h00;
      o_gate      <= 1'b0;
      o_cc_num    <= 7'h00;
      o_cc_val    <= 7'h00;
      o_bend      <= 14'h2000;
      o_msg_valid <= 1'b0;
    end else begin
      o_msg_valid <= 1'b0;
      if (complete && chan_ok) begin
        case (status)
          4'h9, 4'h8: begin
            if ((status == 4'h9) && (msg_d2 != 7'h00)) begin
              o_note      <= msg_d1;
              o_velocity  <= msg_d2;
              o_gate      <= 1'b1;
              o_msg_valid <= 1'b1;
            end else if (o_gate && (msg_d1 == o_note)) begin
              o_gate      <= 1'b0;
              o_msg_valid <= 1'b1;
            end
          end
          4'hB: begin
            o_cc_num    <= msg_d1;
            o_cc_val    <= msg_d2;
            o_msg_valid <= 1'b1;
          end
          4'hE: begin
            o_bend      <= {msg_d2, msg_d1};
            o_msg_valid <= 1'b1;
          end
          default: o_msg_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: directed scenarios plus random byte
// streams compared against a queue-based message model.
module tb_midi_msg_parser;

  localparam logic [3:0] CH = 4'd0;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic [6:0]  o_note, o_velocity, o_cc_num, o_cc_val;
  logic        o_gate, o_msg_valid;
  logic [13:0] o_bend;

  int checks = 0;
  int passes = 0;

  // Reference model state: expected outputs plus message framing
  int       m_note, m_vel, m_gate, m_cc_num, m_cc_val, m_bend, m_pulse;
  bit [7:0] m_status;
  bit       m_rs, m_sysex;
  int       m_data[$];

  midi_msg_parser #(.CHANNEL(CH), .OMNI(1'b0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_note(o_note), .o_velocity(o_velocity), .o_gate(o_gate),
    .o_cc_num(o_cc_num), .o_cc_val(o_cc_val), .o_bend(o_bend),
    .o_msg_valid(o_msg_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, " note"},      int'(o_note),      m_note);
    checkOutput({ctx, " velocity"},  int'(o_velocity),  m_vel);
    checkOutput({ctx, " gate"},      int'(o_gate),      m_gate);
    checkOutput({ctx, " cc_num"},    int'(o_cc_num),    m_cc_num);
    checkOutput({ctx, " cc_val"},    int'(o_cc_val),    m_cc_val);
    checkOutput({ctx, " bend"},      int'(o_bend),      m_bend);
    checkOutput({ctx, " msg_valid"}, int'(o_msg_valid), m_pulse);
  endtask

  function automatic void modelReset();
    m_note = 0; m_vel = 0; m_gate = 0; m_cc_num = 0; m_cc_val = 0;
    m_bend = 'h2000; m_pulse = 0;
    m_status = 8'h00; m_rs = 0; m_sysex = 0;
    m_data.delete();
  endfunction

  function automatic void modelApply();
    int kind, a, c;
    if (m_status[3:0] != CH) return;
    kind = m_status >> 4;
    a = m_data[0];
    c = (m_data.size() > 1) ? m_data[1] : 0;
    if (kind == 9 && c != 0) begin
      m_note = a; m_vel = c; m_gate = 1; m_pulse = 1;
    end else if (kind == 8 || kind == 9) begin
      if (m_gate == 1 && a == m_note) begin m_gate = 0; m_pulse = 1; end
    end else if (kind == 'hB) begin
      m_cc_num = a; m_cc_val = c; m_pulse = 1;
    end else if (kind == 'hE) begin
      m_bend = c * 128 + a; m_pulse = 1;
    end
  endfunction

  function automatic void modelByte(input bit [7:0] b);
    int need;
    if (b >= 8'hF8) return;
    if (b >= 8'h80 && b <= 8'hEF) begin
      m_status = b; m_rs = 1; m_sysex = 0; m_data.delete();
    end else if (b == 8'hF0) begin
      m_rs = 0; m_sysex = 1; m_data.delete();
    end else if (b >= 8'hF1) begin
      m_rs = 0; m_sysex = 0; m_data.delete();
    end else if (!m_sysex && m_rs) begin
      m_data.push_back(int'(b));
      need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
      if (m_data.size() == need) begin
        modelApply();
        m_data.delete();
      end
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input bit v);
    @(negedge i_clk);
    i_byte = b;
    i_byte_valid = v;
    m_pulse = 0;
    if (v) modelByte(b);
    @(posedge i_clk);
    #1;
    checkAll("byte");
  endtask

  task automatic sendSeq(input logic [7:0] seq[$]);
    foreach (seq[k]) applyStimulus(seq[k], 1'b1);
    applyStimulus(8'h00, 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_byte_valid = 1'b0;
    modelReset();
    #1;
    checkAll("async reset");
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  function automatic logic [7:0] randByte();
    int r, sel;
    logic [7:0] st[7] = '{8'h80, 8'h90, 8'hB0, 8'hE0, 8'hA0, 8'hC0, 8'hD0};
    r = $urandom_range(0, 99);
    if (r < 25) begin
      sel = $urandom_range(0, 6);
      return st[sel] | (($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
    end
    if (r < 30) return 8'hF8 + 8'($urandom_range(0, 7));
    if (r < 33) return 8'hF0;
    if (r < 36) return 8'hF7;
    if (r < 38) return 8'hF1 + 8'($urandom_range(0, 5));
    if (r < 50) return 8'h00;
    if (r < 75) return 8'h3C + 8'($urandom_range(0, 3));
    return 8'($urandom_range(0, 127));
  endfunction

  initial begin
    i_rst = 1'b1;
    i_byte = 8'h00;
    i_byte_valid = 1'b0;
    modelReset();
    repeat (2) @(posedge i_clk);
    #1;
    checkAll("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Basic note on
    sendSeq('{8'h90, 8'h3C, 8'h64});
    checkOutput("note on value", int'(o_note), 60);

    // Running status note on, then running-status note off via vel 0
    sendSeq('{8'h40, 8'h50});
    checkOutput("running note", int'(o_note), 64);
    sendSeq('{8'h40, 8'h00});
    checkOutput("vel held", int'(o_velocity), 80);

    // Note-off for a non-current note, then the current one
    sendSeq('{8'h90, 8'h40, 8'h50});
    sendSeq('{8'h80, 8'h3C, 8'h00});
    checkOutput("gate kept", int'(o_gate), 1);
    sendSeq('{8'h80, 8'h40, 8'h00});

    // Realtime bytes interleaved back-to-back
    sendSeq('{8'hB0, 8'hF8, 8'h07, 8'hFE, 8'h7F});
    checkOutput("cc val", int'(o_cc_val), 127);

    // Channel filter, sysex discard, accepted bend
    sendSeq('{8'hE1, 8'h00, 8'h7F});
    sendSeq('{8'hF0, 8'h11, 8'h22, 8'hF7, 8'h10});
    sendSeq('{8'hE0, 8'h00, 8'h7F});
    checkOutput("bend value", int'(o_bend), 'h3F80);

    // Reset mid-message loses the partial message and running status
    applyStimulus(8'h90, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    pulseReset();
    sendSeq('{8'h64});

    // Random byte streams, mostly back-to-back with occasional gaps
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) pulseReset();
      else applyStimulus(randByte(), ($urandom_range(0, 9) != 0));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
